// File: rtl/mix_pipe_pkg.sv
// mix_pipe_pkg: default parameters and stage payload type for mix_pipe.
package mix_pipe_pkg;
    localparam int MIX_IN_W = 3;
    localparam int MIX_ACC_W = 9;
    localparam int MIX_OUT_W = 10;
    localparam logic [MIX_ACC_W-1:0] MIX_KEY = 9'd163;
    typedef struct packed {
        logic [MIX_ACC_W-1:0] a;
        logic [MIX_ACC_W-1:0] xb;
    } stage_t;
endpackage

// File: rtl/mix_pipe_if.sv
// mix_pipe_if: valid/ready input and output streams of mix_pipe.
interface mix_pipe_if
    import mix_pipe_pkg::*;
#(
    parameter int IN_W = MIX_IN_W,
    parameter int OUT_W = MIX_OUT_W
);
    logic in_valid;
    logic [IN_W-1:0] in_data;
    logic in_ready;
    logic out_valid;
    logic [OUT_W-1:0] out_data;
    logic out_ready;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/mix_pipe_slice.sv
// mix_pipe_slice: one elastic register slice; an empty slice always loads.
module mix_pipe_slice
    import mix_pipe_pkg::*;
#(
    parameter type T = stage_t
) (
    input  logic clk,
    input  logic rst,
    input  logic v_in,
    input  T     d_in,
    input  logic en_nxt,
    output logic en,
    output logic v,
    output T     q
);
    logic v_q, v_d;
    T d_q, d_d;
    always_comb begin
        en = !v_q || en_nxt;
        v_d = en ? v_in : v_q;
        d_d = en ? d_in : d_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end
    assign v = v_q;
    assign q = d_q;
endmodule

// File: rtl/mix_pipe.sv
// mix_pipe: three-stage elastic keyed XOR-multiply / OR-subtract fold / zero-select mixer.
// Define MIX_PIPE_CSUM_EN to add the csum port (XOR of every transferred result).
module mix_pipe
    import mix_pipe_pkg::*;
#(
    parameter int IN_W = MIX_IN_W,
    parameter int ACC_W = MIX_ACC_W,
    parameter int OUT_W = MIX_OUT_W,
    parameter logic [ACC_W-1:0] KEY = MIX_KEY
) (
    input  logic clk,
    input  logic rst,
    mix_pipe_if.slave io
`ifdef MIX_PIPE_CSUM_EN
    ,
    output logic [OUT_W-1:0] csum
`endif
);
    typedef struct packed {
        logic [ACC_W-1:0] a;
        logic [ACC_W-1:0] xb;
    } st_t;
    typedef logic [OUT_W-1:0] out_t;
    logic en1, en2, en3, v1, v2, v3;
    logic [ACC_W-1:0] x, a1, b2;
    st_t d1, d2, q1, q2;
    out_t d3, q3;
    always_comb begin
        x = ACC_W'(io.in_data);
        a1 = (x ^ KEY) * x;
        d1 = '{a: a1, xb: x};
        b2 = (q1.a | q1.xb) - (q1.a >> 1);
        d2 = '{a: q1.a, xb: b2};
        d3 = (q2.xb != '0) ? OUT_W'(q2.xb) : OUT_W'(q2.a);
    end
    mix_pipe_slice #(.T(st_t)) u_s1 (
        .clk(clk), .rst(rst), .v_in(io.in_valid), .d_in(d1),
        .en_nxt(en2), .en(en1), .v(v1), .q(q1)
    );
    mix_pipe_slice #(.T(st_t)) u_s2 (
        .clk(clk), .rst(rst), .v_in(v1), .d_in(d2),
        .en_nxt(en3), .en(en2), .v(v2), .q(q2)
    );
    mix_pipe_slice #(.T(out_t)) u_s3 (
        .clk(clk), .rst(rst), .v_in(v2), .d_in(d3),
        .en_nxt(io.out_ready), .en(en3), .v(v3), .q(q3)
    );
    assign io.in_ready = en1;
    assign io.out_valid = v3;
    assign io.out_data = q3;
`ifdef MIX_PIPE_CSUM_EN
    logic [OUT_W-1:0] csum_q, csum_d;
    always_comb csum_d = (v3 && io.out_ready) ? csum_q ^ q3 : csum_q;
    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else csum_q <= csum_d;
    end
    assign csum = csum_q;
`endif
endmodule
